// File: rtl/line_window5.sv
// Vertical 5-row window generator: four circular line buffers feed rows y-4..y
// of the same column to the downstream 5-tap cascade, one cycle after each accepted pixel.
module line_window5 #(
    parameter int DATA_W = 8,
    parameter int LINE_W = 1280,
    parameter int COL_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              sof,
    output logic [DATA_W-1:0] pa,
    output logic [DATA_W-1:0] pb,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] pd,
    output logic [DATA_W-1:0] pe,
    output logic              dout_valid,
    output logic [COL_W-1:0]  dout_col,
    output logic              dout_eol
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_W - 1);
    localparam logic [2:0]       FULL     = 3'd4;

    logic [DATA_W-1:0] lb0 [LINE_W];
    logic [DATA_W-1:0] lb1 [LINE_W];
    logic [DATA_W-1:0] lb2 [LINE_W];
    logic [DATA_W-1:0] lb3 [LINE_W];

    logic [COL_W-1:0]  col;
    logic [COL_W-1:0]  cur_col;
    logic [COL_W-1:0]  next_col;
    logic [2:0]        lines_done;
    logic              at_eol;
    logic [DATA_W-1:0] o0, o1, o2, o3;

    // Warm-up line count stops at FULL so it never wraps back into warm-up.
    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        return (v >= FULL) ? FULL : v + 3'd1;
    endfunction

    // A start-of-frame pixel is always column 0, whatever the counter says.
    always_comb begin
        cur_col  = sof ? '0 : col;
        at_eol   = (cur_col == LAST_COL);
        next_col = at_eol ? '0 : cur_col + COL_W'(1);
    end

    assign o0 = lb0[cur_col];
    assign o1 = lb1[cur_col];
    assign o2 = lb2[cur_col];
    assign o3 = lb3[cur_col];

    // Line buffers shift one row deeper per accepted pixel; contents are
    // left unreset and masked by the warm-up count instead.
    always_ff @(posedge clk) begin
        if (din_valid) begin
            lb0[cur_col] <= din;
            lb1[cur_col] <= o0;
            lb2[cur_col] <= o1;
            lb3[cur_col] <= o2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col        <= '0;
            lines_done <= '0;
            pa         <= '0;
            pb         <= '0;
            pc         <= '0;
            pd         <= '0;
            pe         <= '0;
            dout_valid <= 1'b0;
            dout_col   <= '0;
            dout_eol   <= 1'b0;
        end else begin
            dout_valid <= din_valid && !sof && (lines_done == FULL);
            if (din_valid) begin
                col <= next_col;
                if (sof)
                    lines_done <= '0;
                else if (at_eol)
                    lines_done <= sat_inc(lines_done);
                pa       <= o3;
                pb       <= o2;
                pc       <= o1;
                pd       <= o0;
                pe       <= din;
                dout_col <= cur_col;
                dout_eol <= at_eol;
            end
        end
    end

endmodule

// File: tb/tb_line_window5.sv
// Scoreboard bench for line_window5 with an 8-pixel line: stimulus pushes the
// expected window for each pixel that should be valid, a monitor pops on dout_valid.
module tb_line_window5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] din = '0;
    logic       din_valid = 1'b0;
    logic       sof = 1'b0;
    logic [7:0] pa, pb, pc, pd, pe;
    logic       dout_valid;
    logic [2:0] dout_col;
    logic       dout_eol;

    typedef struct packed {
        logic [7:0] a, b, c, d, e;
        logic [2:0] col;
        logic       eol;
    } win_t;

    win_t q[$];
    int   checks = 0;
    int   errors = 0;

    line_window5 #(.DATA_W(8), .LINE_W(8), .COL_W(3)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sof(sof),
        .pa(pa), .pb(pb), .pc(pc), .pd(pd), .pe(pe),
        .dout_valid(dout_valid), .dout_col(dout_col), .dout_eol(dout_eol)
    );

    always #5 clk = ~clk;

    function automatic win_t mk(input int r, input int c);
        win_t w;
        w.a   = 8'((r - 4) * 16 + c);
        w.b   = 8'((r - 3) * 16 + c);
        w.c   = 8'((r - 2) * 16 + c);
        w.d   = 8'((r - 1) * 16 + c);
        w.e   = 8'(r * 16 + c);
        w.col = 3'(c);
        w.eol = (c == 7);
        return w;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Monitor: every presented window must match the oldest outstanding expectation.
    always @(negedge clk) begin
        win_t got, exp;
        if (rst && dout_valid) begin
            got = {pa, pb, pc, pd, pe, dout_col, dout_eol};
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_valid got=%h exp=none", got);
            end else begin
                exp = q.pop_front();
                check("window", 64'(got), 64'(exp));
            end
        end
    end

    task automatic pix(input int r, input int c, input bit s);
        @(posedge clk); #1;
        din       = 8'(r * 16 + c);
        din_valid = 1'b1;
        sof       = s;
        if (r >= 4 && !s) q.push_back(mk(r, c));
    endtask

    task automatic stop();
        @(posedge clk); #1;
        din_valid = 1'b0;
        sof       = 1'b0;
    endtask

    // Two idle cycles after an accepted row-5 pixel, with a stray sof that must be ignored.
    task automatic idle_check(input int c);
        @(posedge clk); #1;
        din_valid = 1'b0;
        sof       = 1'b1;
        din       = 8'($urandom);
        @(negedge clk);
        @(negedge clk);
        check("stall_valid", 64'(dout_valid), 64'(0));
        check("stall_hold", 64'({pa, pe, dout_col}), 64'({8'(16 + c), 8'(80 + c), 3'(c)}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Held in reset while the input toggles.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            din_valid = i[0];
            sof       = ~i[0];
            din       = 8'hA5;
            @(negedge clk);
            check("reset_state", 64'({pa, pb, pc, pd, pe, dout_valid, dout_col}), 64'(0));
        end
        stop();
        rst = 1'b1;

        // Frame 1: rows 0..4 contiguous, sof on the first pixel.
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 8; c++)
                pix(r, c, (r == 0 && c == 0));
        // Row 5 with gaps after every pixel.
        for (int c = 0; c < 8; c++) begin
            pix(5, c, 1'b0);
            idle_check(c);
        end
        for (int c = 0; c < 3; c++) pix(6, c, 1'b0);

        // New frame starts at what would have been row 6 col 3.
        pix(0, 0, 1'b1);
        for (int c = 1; c < 8; c++) pix(0, c, 1'b0);
        for (int r = 1; r < 5; r++)
            for (int c = 0; c < 8; c++)
                pix(r, c, 1'b0);
        for (int c = 0; c < 4; c++) pix(5, c, 1'b0);
        stop();

        // Asynchronous reset between clock edges mid-row 5.
        @(negedge clk);
        check("pre_reset_valid", 64'(dout_valid), 64'(1));
        #2 rst = 1'b0;
        #1;
        check("async_reset", 64'({pa, pb, pc, pd, pe, dout_valid, dout_col, dout_eol}), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // sof-less restart: 32 warm-up pixels, 33rd is the first valid window.
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++)
                pix(r, c, 1'b0);
        pix(4, 0, 1'b0);
        pix(4, 1, 1'b0);
        stop();
        repeat (4) @(negedge clk);
        check("queue_drained", 64'(q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
